sop_sweep: RTL and testbench

//  Sequential stimulus/capture stage wrapped around the combinational sop block.

---
 rtl/sop_sweep_pkg.sv | 23 ++
 rtl/sop_sweep_settle_cnt.sv | 36 +++
 rtl/sop_sweep.sv | 115 +++++++++++
 tb/tb_sop_sweep.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sop_sweep_pkg.sv
// Shared definitions for the sop sweep self-check: state encodings,
// the expected sop truth table and the vector count.
package sop_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // bit k = o1 for {i1,i2,i3,i4} = k; minterms 3,5,12,13,14,15
  localparam logic [15:0] SOP_EXP_TT  = 16'hF028;
  localparam int          SOP_NUM_VEC = 16;
  localparam logic [3:0]  SOP_LAST_IDX = 4'(SOP_NUM_VEC - 1);

  // Captured bit disagrees with the expected table at this index.
  function automatic logic tt_mismatch(input logic [15:0] exp_tt,
                                       input logic [3:0]  idx,
                                       input logic        obs);
    return obs ^ exp_tt[idx];
  endfunction

endpackage

// File: rtl/sop_sweep_settle_cnt.sv
// Settle counter: counts the cycles a vector has been held and flags
// the last one (count == SETTLE-1), then wraps to zero.
module sop_sweep_settle_cnt #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [3:0] TC_VAL = 4'(SETTLE - 1);

  logic [3:0] scnt_r;

  // Clear on sweep start, advance while running, wrap on terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scnt_r <= 4'd0;
    end else if (clr) begin
      scnt_r <= 4'd0;
    end else if (en) begin
      if (tc) begin
        scnt_r <= 4'd0;
      end else begin
        scnt_r <= scnt_r + 4'd1;
      end
    end else begin
      scnt_r <= scnt_r;
    end
  end

  assign tc = (scnt_r == TC_VAL);

endmodule

// File: rtl/sop_sweep.sv
// On-chip self-check for the sop block: walks all 16 input vectors,
// captures o1 after each has settled, and compares the resulting
// truth table against the expected one.
module sop_sweep
  import sop_sweep_pkg::*;
#(
  parameter int          SETTLE = 2,
  parameter logic [15:0] EXP_TT = SOP_EXP_TT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        drv_i1,
  output logic        drv_i2,
  output logic        drv_i3,
  output logic        drv_i4,
  input  logic        sop_o1,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] tt,
  output logic [3:0]  fail_idx,
  output logic [4:0]  err_cnt
);

  state_t     state_r;
  logic [3:0] idx_r;
  logic [3:0] drv_r;
  logic       tc_s;
  logic       clr_s;
  logic       en_s;
  logic       mism_s;
  logic [4:0] err_next_s;

  // Start is honoured from IDLE or DONE only; a start during RUN is ignored.
  always_comb begin
    clr_s      = start && (state_r != ST_RUN);
    en_s       = (state_r == ST_RUN);
    mism_s     = tt_mismatch(EXP_TT, idx_r, sop_o1);
    err_next_s = err_cnt + {4'd0, mism_s};
  end

  sop_sweep_settle_cnt #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .en    (en_s),
    .tc    (tc_s)
  );

  // Sweep FSM with vector index, capture/compare bookkeeping and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      idx_r    <= 4'd0;
      drv_r    <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      tt       <= 16'd0;
      fail_idx <= 4'd0;
      err_cnt  <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r  <= ST_RUN;
            idx_r    <= 4'd0;
            drv_r    <= 4'd0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            tt       <= 16'd0;
            fail_idx <= 4'd0;
            err_cnt  <= 5'd0;
          end
        end
        ST_RUN: begin
          if (tc_s) begin
            tt[idx_r] <= sop_o1;
            err_cnt   <= err_next_s;
            // First mismatch is the one seen while the count is still zero.
            if (mism_s && (err_cnt == 5'd0)) begin
              fail_idx <= idx_r;
            end
            if (idx_r == SOP_LAST_IDX) begin
              state_r <= ST_DONE;
              drv_r   <= 4'd0;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_next_s == 5'd0);
            end else begin
              idx_r <= idx_r + 4'd1;
              drv_r <= idx_r + 4'd1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          drv_r   <= 4'd0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  assign drv_i1 = drv_r[3];
  assign drv_i2 = drv_r[2];
  assign drv_i3 = drv_r[1];
  assign drv_i4 = drv_r[0];

endmodule

// File: tb/tb_sop_sweep.sv
// Randomized self-checking bench for sop_sweep: two instances (SETTLE=2
// and SETTLE=1) drive a table-driven sop model, and every result is
// compared against a truth-table reference built from the sop minterms.
module tb_sop_sweep;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [15:0] resp;
  logic        sel;

  logic a_i1, a_i2, a_i3, a_i4, b_i1, b_i2, b_i3, b_i4;
  logic [3:0]  drv_a, drv_b, drv_m;
  logic        o1_a, o1_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [15:0] tt_a, tt_b;
  logic [3:0]  fidx_a, fidx_b;
  logic [4:0]  err_a, err_b;
  logic        busy_m, done_m, pass_m;
  logic [15:0] tt_m;
  logic [3:0]  fidx_m;
  logic [4:0]  err_m;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign drv_a = {a_i1, a_i2, a_i3, a_i4};
  assign drv_b = {b_i1, b_i2, b_i3, b_i4};
  // Sop stand-in: o1 looked up from the current response table.
  assign o1_a  = resp[drv_a];
  assign o1_b  = resp[drv_b];

  assign drv_m  = sel ? drv_b  : drv_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign done_m = sel ? done_b : done_a;
  assign pass_m = sel ? pass_b : pass_a;
  assign tt_m   = sel ? tt_b   : tt_a;
  assign fidx_m = sel ? fidx_b : fidx_a;
  assign err_m  = sel ? err_b  : err_a;

  sop_sweep #(.SETTLE(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .drv_i1(a_i1), .drv_i2(a_i2), .drv_i3(a_i3), .drv_i4(a_i4),
    .sop_o1(o1_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .tt(tt_a), .fail_idx(fidx_a), .err_cnt(err_a)
  );

  sop_sweep #(.SETTLE(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .drv_i1(b_i1), .drv_i2(b_i2), .drv_i3(b_i3), .drv_i4(b_i4),
    .sop_o1(o1_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .tt(tt_b), .fail_idx(fidx_b), .err_cnt(err_b)
  );

  // Golden sop truth table built from its minterm list.
  function automatic logic [15:0] sop_ref();
    int mt [6] = '{3, 5, 12, 13, 14, 15};
    logic [15:0] t = 16'd0;
    for (int i = 0; i < 6; i++) t[mt[i]] = 1'b1;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic s, input logic v);
    if (s) start_b = v;
    else   start_a = v;
  endtask

  // One full sweep on the selected instance with response table r.
  // restart_at >= 0 pulses start again at that RUN cycle (must be ignored).
  task automatic run_sweep(input logic s, input logic [15:0] r, input int restart_at);
    int          settle;
    int          cyc;
    int          exp_err;
    int          exp_fail;
    logic [15:0] gold;
    logic [15:0] diff;
    settle   = s ? 1 : 2;
    gold     = sop_ref();
    diff     = gold ^ r;
    exp_err  = 0;
    exp_fail = -1;
    for (int k = 0; k < 16; k++) begin
      if (diff[k]) begin
        exp_err++;
        if (exp_fail < 0) exp_fail = k;
      end
    end
    sel  = s;
    resp = r;
    @(negedge clk);
    set_start(s, 1'b1);
    @(negedge clk);
    set_start(s, 1'b0);
    cyc = 0;
    chk("start_done_clr", {31'd0, done_m}, 32'd0);
    chk("start_pass_clr", {31'd0, pass_m}, 32'd0);
    while (done_m !== 1'b1 && cyc < 400) begin
      chk("busy_run", {31'd0, busy_m}, 32'd1);
      chk("drv_seq", {28'd0, drv_m}, 32'(cyc / settle));
      if (cyc == restart_at) set_start(s, 1'b1);
      @(negedge clk);
      set_start(s, 1'b0);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(16 * settle));
    chk("busy_done", {31'd0, busy_m}, 32'd0);
    chk("drv_done", {28'd0, drv_m}, 32'd0);
    chk("tt", {16'd0, tt_m}, {16'd0, r});
    chk("err_cnt", {27'd0, err_m}, 32'(exp_err));
    chk("pass", {31'd0, pass_m}, (exp_err == 0) ? 32'd1 : 32'd0);
    if (exp_fail >= 0) chk("fail_idx", {28'd0, fidx_m}, 32'(exp_fail));
  endtask

  task automatic chk_all_zero(input string tag, input logic s);
    sel = s;
    #1;
    chk({tag, "_busy"}, {31'd0, busy_m}, 32'd0);
    chk({tag, "_done"}, {31'd0, done_m}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass_m}, 32'd0);
    chk({tag, "_tt"},   {16'd0, tt_m},   32'd0);
    chk({tag, "_fidx"}, {28'd0, fidx_m}, 32'd0);
    chk({tag, "_err"},  {27'd0, err_m},  32'd0);
    chk({tag, "_drv"},  {28'd0, drv_m},  32'd0);
  endtask

  initial begin
    logic [15:0] gold;
    logic [15:0] r;
    logic        s;
    gold    = sop_ref();
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    sel     = 1'b0;
    resp    = gold;
    repeat (3) @(negedge clk);
    chk_all_zero("rst_a", 1'b0);
    chk_all_zero("rst_b", 1'b1);
    reset = 1'b0;

    // Real sop, then stuck-at-0, inverted (each started from DONE).
    run_sweep(1'b0, gold, -1);
    run_sweep(1'b0, 16'h0000, -1);
    run_sweep(1'b0, ~gold, -1);
    // Re-start during RUN must be ignored.
    run_sweep(1'b0, gold, 5);

    // Reset ten cycles into a sweep, then a clean sweep.
    sel  = 1'b0;
    resp = gold;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    chk_all_zero("midrst", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    run_sweep(1'b0, gold, -1);

    // SETTLE=1 instance.
    run_sweep(1'b1, gold, -1);
    run_sweep(1'b1, ~gold, 3);

    // Randomized fault tables, instances and idle gaps.
    for (int it = 0; it < 10; it++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 3) == 0) r = gold;
      s = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_sweep(s, r, int'($urandom_range(0, 40)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
